subsys_dispatch: RTL and testbench

//  Menu/launcher on the other end of the subsystem enable handshake. Conditions the raw keys,

---
 rtl/subsys_dispatch.sv | 170 +++++++++++++++++
 tb/tb_subsys_dispatch.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/subsys_dispatch.sv
// Menu/launcher for the subsystem enable handshake: debounced key navigation,
// active-low launch of the selected subsystem, and reclaim on done, quit or timeout.
module deb_key #(
  parameter int DEB_CYC = 20000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic pulse
);
  localparam int CW = $clog2(DEB_CYC + 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          rise;

  assign rise = sync[1] & ~level & (cnt == CW'(DEB_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
      pulse <= 1'b0;
    end else begin
      sync  <= {sync[0], raw};
      pulse <= rise;
      // any cycle agreeing with the accepted level restarts the count
      if (sync[1] != level) begin
        if (cnt == CW'(DEB_CYC - 1)) begin
          level <= sync[1];
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end
endmodule

module subsys_dispatch #(
  parameter int N_SUB   = 4,
  parameter int SEL_W   = 2,
  parameter int DEB_CYC = 20000,
  parameter int ARM_CYC = 4,
  parameter int TO_CYC  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       keys,
  input  logic [N_SUB-1:0] en_back,
  output logic [N_SUB-1:0] en_sub,
  output logic [SEL_W-1:0] sel,
  output logic [15:0]      menu_led,
  output logic             busy,
  output logic [1:0]       last_exit
);
  localparam int AW = $clog2(ARM_CYC + 1);
  localparam int TW = (TO_CYC > 1) ? $clog2(TO_CYC + 1) : 1;

  typedef enum logic [1:0] {MENU, LAUNCH, RUN, DRAIN} state_t;

  state_t           st, st_n;
  logic [SEL_W-1:0] sel_n;
  logic [N_SUB-1:0] en_n, eb_s1, eb_s2;
  logic [1:0]       le_n;
  logic [AW-1:0]    arm_cnt, arm_n;
  logic [TW-1:0]    to_cnt, to_n;
  logic [3:0]       key_lvl, key_pls;
  logic             unused_keys;

  assign unused_keys = ^keys[6:4];

  for (genvar k = 0; k < 4; k++) begin : g_key
    deb_key #(.DEB_CYC(DEB_CYC)) u_key (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (keys[k]),
      .level(key_lvl[k]),
      .pulse(key_pls[k])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eb_s1 <= '0;
      eb_s2 <= '0;
    end else begin
      eb_s1 <= en_back;
      eb_s2 <= eb_s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= MENU;
      sel       <= '0;
      en_sub    <= '1;
      last_exit <= 2'b00;
      arm_cnt   <= '0;
      to_cnt    <= '0;
    end else begin
      st        <= st_n;
      sel       <= sel_n;
      en_sub    <= en_n;
      last_exit <= le_n;
      arm_cnt   <= arm_n;
      to_cnt    <= to_n;
    end
  end

  always_comb begin
    st_n  = st;
    sel_n = sel;
    en_n  = en_sub;
    le_n  = last_exit;
    arm_n = arm_cnt;
    to_n  = to_cnt;
    case (st)
      MENU: begin
        en_n = '1;
        if (key_pls[3]) begin
          st_n  = LAUNCH;
          en_n  = ~(N_SUB'(1) << sel);
          arm_n = '0;
        end else if (key_pls[1] && !key_pls[2]) begin
          sel_n = (sel == SEL_W'(N_SUB - 1)) ? '0 : sel + 1'b1;
        end else if (key_pls[2] && !key_pls[1]) begin
          sel_n = (sel == '0) ? SEL_W'(N_SUB - 1) : sel - 1'b1;
        end
      end
      LAUNCH: begin
        // subsystem gets ARM_CYC cycles to clear a stale done flag
        if (arm_cnt == AW'(ARM_CYC - 1)) begin
          st_n = RUN;
          to_n = '0;
        end else begin
          arm_n = arm_cnt + 1'b1;
        end
      end
      RUN: begin
        to_n = to_cnt + 1'b1;
        if (eb_s2[sel]) begin
          st_n = DRAIN;
          le_n = 2'b01;
          en_n = '1;
        end else if (key_pls[0]) begin
          st_n = DRAIN;
          le_n = 2'b10;
          en_n = '1;
        end else if (TO_CYC != 0 && to_cnt == TW'(TO_CYC - 1)) begin
          st_n = DRAIN;
          le_n = 2'b11;
          en_n = '1;
        end
      end
      DRAIN: begin
        en_n = '1;
        if (key_lvl == 4'b0000) st_n = MENU;
      end
      default: st_n = MENU;
    endcase
  end

  assign busy     = (st != MENU);
  assign menu_led = (st == MENU) ? (16'(1) << sel) : 16'h0000;
endmodule

// File: tb/tb_subsys_dispatch.sv
// Directed plus randomized bench for subsys_dispatch; a second instance exercises the timeout.
module tb_subsys_dispatch;
  localparam int N = 4;
  localparam int DEB = 4;
  localparam int ARM = 4;
  localparam int TO = 100;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [6:0]   keys;
  logic [N-1:0] en_back;
  logic [N-1:0] en_sub, en_sub2;
  logic [1:0]   sel, sel2;
  logic [15:0]  menu_led, menu_led2;
  logic         busy, busy2;
  logic [1:0]   last_exit, last_exit2;

  int checks = 0;
  int failures = 0;
  int msel = 0;

  always #5 clk = ~clk;

  subsys_dispatch #(.N_SUB(N), .SEL_W(2), .DEB_CYC(DEB), .ARM_CYC(ARM), .TO_CYC(0)) dut (
    .clk(clk), .rst_n(rst_n), .keys(keys), .en_back(en_back), .en_sub(en_sub),
    .sel(sel), .menu_led(menu_led), .busy(busy), .last_exit(last_exit));

  subsys_dispatch #(.N_SUB(N), .SEL_W(2), .DEB_CYC(DEB), .ARM_CYC(ARM), .TO_CYC(TO)) dut2 (
    .clk(clk), .rst_n(rst_n), .keys(keys), .en_back(en_back), .en_sub(en_sub2),
    .sel(sel2), .menu_led(menu_led2), .busy(busy2), .last_exit(last_exit2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [6:0] m, input int hold);
    keys = m;
    repeat (hold) @(negedge clk);
    keys = '0;
    repeat (12) @(negedge clk);
  endtask

  task automatic wait_en(input logic [N-1:0] exp, input int budget, input string tag);
    int n = 0;
    while (en_sub !== exp && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(en_sub), 32'(exp));
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(busy), 32'd0);
  endtask

  task automatic step(input bit nxt, input int hold, input string tag);
    press(nxt ? 7'h02 : 7'h04, hold);
    msel = nxt ? (msel + 1) % N : (msel + N - 1) % N;
    chk({tag, "_sel"}, 32'(sel), 32'(msel));
    chk({tag, "_led"}, 32'(menu_led), 32'(1) << msel);
  endtask

  task automatic goto_sel(input int target);
    int g = 0;
    while (msel != target && g < 8) begin
      step(1'b1, 10, "goto");
      g++;
    end
  endtask

  task automatic launch(input logic [N-1:0] exp, input string tag);
    keys = 7'h08;
    wait_en(exp, DEB + 6, tag);
  endtask

  initial begin
    int n;
    keys    = '0;
    en_back = '0;
    rst_n   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_en_sub", 32'(en_sub), 32'hF);
    chk("rst_sel", 32'(sel), 0);
    chk("rst_led", 32'(menu_led), 32'h0001);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_exit", 32'(last_exit), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // navigation with wrap in both directions
    repeat (3) step(1'b1, 10, "next");
    repeat (4) step(1'b0, 10, "prev");
    for (int i = 0; i < 10; i++) step(1'($urandom_range(0, 1)), $urandom_range(6, 14), "rnd");

    press(7'h01, 10);
    chk("menu_quit_busy", 32'(busy), 0);
    chk("menu_quit_sel", 32'(sel), 32'(msel));

    // launch sel 2, foreign done flags ignored, own done reclaims
    goto_sel(2);
    launch(4'b1011, "l2_en_sub");
    chk("l2_busy", 32'(busy), 1);
    chk("l2_led", 32'(menu_led), 0);
    repeat (10) @(negedge clk);
    keys = '0;
    en_back = 4'b1011;
    repeat (12) @(negedge clk);
    chk("l2_foreign", 32'(en_sub), 32'b1011);
    en_back = 4'b0100;
    wait_en(4'hF, 10, "l2_done_en");
    chk("l2_exit", 32'(last_exit), 32'b01);
    en_back = '0;
    wait_idle(20, "l2_idle");
    chk("l2_sel", 32'(sel), 2);
    chk("l2_led_back", 32'(menu_led), 32'h0004);

    // quit during run, held key keeps DRAIN, no relaunch
    goto_sel(1);
    launch(4'b1101, "l1_en_sub");
    repeat (10) @(negedge clk);
    keys = '0;
    repeat (12) @(negedge clk);
    keys = 7'h01;
    repeat (10) @(negedge clk);
    chk("q_en_sub", 32'(en_sub), 32'hF);
    chk("q_exit", 32'(last_exit), 32'b10);
    chk("q_busy", 32'(busy), 1);
    repeat (40) @(negedge clk);
    chk("q_drain_held", 32'(busy), 1);
    keys = '0;
    wait_idle(20, "q_idle");
    repeat (20) @(negedge clk);
    chk("q_no_relaunch", 32'(en_sub), 32'hF);
    chk("q_menu", 32'(busy), 0);
    chk("q_sel", 32'(sel), 1);

    // stale done flag at launch is masked
    goto_sel(0);
    en_back = 4'b0001;
    launch(4'b1110, "st_en_sub");
    @(negedge clk);
    en_back = '0;
    repeat (8) @(negedge clk);
    chk("st_masked", 32'(en_sub), 32'b1110);
    chk("st_busy", 32'(busy), 1);
    chk("st_exit_kept", 32'(last_exit), 32'b10);
    keys = '0;
    repeat (5) @(negedge clk);
    en_back = 4'b0001;
    wait_en(4'hF, 10, "st_done_en");
    chk("st_exit", 32'(last_exit), 32'b01);
    en_back = '0;
    wait_idle(20, "st_idle");

    // glitches and simultaneous next+prev
    keys = 7'h02; repeat (3) @(negedge clk); keys = '0; repeat (12) @(negedge clk);
    chk("gl_next", 32'(sel), 32'(msel));
    keys = 7'h04; repeat (3) @(negedge clk); keys = '0; repeat (12) @(negedge clk);
    chk("gl_prev", 32'(sel), 32'(msel));
    keys = 7'h08; repeat (3) @(negedge clk); keys = '0; repeat (12) @(negedge clk);
    chk("gl_enter", 32'(busy), 0);
    press(7'h06, 10);
    chk("np_sel", 32'(sel), 32'(msel));

    // timeout on the second instance
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    msel = 0;
    repeat (3) @(negedge clk);
    keys = 7'h08;
    n = 0;
    while (en_sub2 !== 4'b1110 && n < DEB + 6) begin
      @(negedge clk);
      n++;
    end
    chk("to_launch", 32'(en_sub2), 32'b1110);
    n = 0;
    while (en_sub2 !== 4'hF && n < 200) begin
      @(negedge clk);
      n++;
      if (n == 10) keys = '0;
    end
    chk("to_cycles", 32'(n), 32'(ARM + TO));
    chk("to_exit", 32'(last_exit2), 32'b11);
    repeat (3) @(negedge clk);
    chk("to_idle", 32'(busy2), 0);

    // async reset mid-run
    chk("rr_running", 32'(en_sub), 32'b1110);
    rst_n = 1'b0;
    #1;
    chk("rr_en_sub", 32'(en_sub), 32'hF);
    chk("rr_sel", 32'(sel), 0);
    chk("rr_busy", 32'(busy), 0);
    chk("rr_exit", 32'(last_exit), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
